multi_ff_bank: RTL and testbench
================================

# multi_ff_bank

Parametrised bank of WIDTH clocked flip-flops that replaces single-bit SR storage with a run-time-selectable SR / JK / D / T register, with per-bit enables, a configurable policy for the forbidden SR input, and illegal-input monitoring. It serves as the general-purpose state-holding primitive for lab datapaths and control blocks that previously instantiated discrete single-bit flip-flops, and it exposes true and complement outputs as the single-bit flip-flops did.

## Interface
- WIDTH, 8: number of flip-flop bits (1..32).
- CNT_W, 8: width of the illegal-event counter.
- RESET_VAL, 0: WIDTH-bit value loaded into q on reset.
- SR_POLICY, 0: next state when S=R=1 in SR mode; 0 = hold, 1 = set, 2 = reset.
- clk  in  1  rising-edge clock; all state changes on this edge.
- rst  in  1  synchronous, active-high reset.
- mode  in  2  function select: 00 SR, 01 JK, 10 D, 11 T; applies to all bits.
- en  in  WIDTH  per-bit enable; a disabled bit holds.
- a  in  WIDTH  S / J / D / T input, by mode.
- b  in  WIDTH  R / K input; ignored in D and T modes.
- illegal_clr  in  1  clears illegal_cnt and illegal.
- q  out  WIDTH  registered state.
- qb  out  WIDTH  registered complement; always equal to ~q.
- illegal  out  1  sticky flag: a forbidden SR input has been seen.
- illegal_cnt  out  CNT_W  saturating count of cycles with a forbidden SR input.

## Operation
- Per bit i, when en[i]=1, q[i] next state:
  - SR: S=0,R=0 hold; S=1,R=0 → 1; S=0,R=1 → 0; S=1,R=1 → per SR_POLICY.
  - JK: 00 hold; 10 → 1; 01 → 0; 11 → toggle.
  - D: q[i] ← a[i].
  - T: a[i]=1 toggles; a[i]=0 holds.
- When en[i]=0, bit i holds regardless of mode, a or b.
- mode is sampled each cycle with no internal latching; a mode change takes effect on the same edge it is sampled.
- Illegal event: any bit with mode=SR, en[i]=1, a[i]=1 and b[i]=1 in a cycle.
  - An event increments illegal_cnt by 1 per cycle, not per bit.
  - illegal_cnt saturates at 2^CNT_W−1.
  - illegal is set on an event and stays set until it is cleared.
- Disabled bits, JK mode with J=K=1, and D and T modes never raise an illegal event.
- illegal_clr without an event in the same cycle: illegal_cnt ← 0, illegal ← 0.
- illegal_clr together with an event: illegal_cnt ← 1, illegal ← 1 (the event is not lost).
- qb is a separately registered complement, not combinational.
  - q and qb are never equal in any cycle, including the reset cycle.

## Timing
- Latency is one cycle: inputs sampled at edge N appear on q, qb, illegal and illegal_cnt after edge N.
- No combinational path from any input to any output.
- Reset (rst=1 at an edge), regardless of en, mode or illegal_clr:
  - q ← RESET_VAL, qb ← ~RESET_VAL.
  - illegal ← 0, illegal_cnt ← 0.
  - An event in the same cycle is discarded.
- Reset asserted mid-sequence: bank state is lost; operation resumes on the first edge after rst falls.
- Before the first reset, outputs are undefined; the bench must apply rst for at least 1 cycle.
- Enable and mode combinations have no ordering constraints; every bit is evaluated independently each edge.

## Test plan
- Reset: WIDTH=8, RESET_VAL=8'hA5; hold rst 2 cycles with en=FF, mode=D, a=00 → q=A5, qb=5A, illegal=0, illegal_cnt=0.
- SR sweep:
  - mode=SR, en=01; drive (S,R) = 10, 00, 01, 11 on successive cycles with SR_POLICY=0 → q[0] = 1, 1, 0, 0.
  - illegal=1 and illegal_cnt=1 after the fourth edge.
  - Repeat with SR_POLICY=1 → q[0]=1 after the 11 cycle.
- JK and T toggle: mode=JK, en=FF, a=b=FF from q=00 for 3 cycles → q = FF, 00, FF, and illegal stays 0. Then mode=T, a=0F → q=F0.
- Per-bit enable: mode=D, a=FF, en=55 from q=00 → q=55 and qb=AA. Then en=00, a=00 for 5 cycles → q stays 55.
- Counter:
  - CNT_W=2, SR mode with S=R=1 held 6 cycles → illegal_cnt = 1, 2, 3, 3, 3, 3.
  - illegal_clr asserted with the event still present → illegal_cnt=1, illegal=1.
  - illegal_clr asserted with the event removed → illegal_cnt=0, illegal=0.
- Reset mid-operation: T mode toggling; assert rst for 1 cycle with S=R=1 also present in SR mode → q=RESET_VAL and illegal_cnt=0 (event dropped); toggling resumes on the next edge.

Source files
------------

// File: rtl/multi_ff_bank.sv
// Bank of WIDTH flip-flops with run-time SR/JK/D/T function select, per-bit enables
// and a sticky/saturating monitor for forbidden SR inputs.
module multi_ff_bank #(
  parameter int unsigned     WIDTH     = 8,
  parameter int unsigned     CNT_W     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int unsigned     SR_POLICY = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             illegal_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [1:0] MODE_SR = 2'b00;
  localparam logic [1:0] MODE_JK = 2'b01;
  localparam logic [1:0] MODE_D  = 2'b10;
  localparam logic [1:0] MODE_T  = 2'b11;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_qb;
  logic             r_illegal;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_next;
  logic             w_event;
  logic [CNT_W-1:0] w_cnt_inc;

  always_comb begin
    w_next = r_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (en[i]) begin
        case (mode)
          MODE_SR: begin
            case ({a[i], b[i]})
              2'b10:   w_next[i] = 1'b1;
              2'b01:   w_next[i] = 1'b0;
              2'b11: begin
                if (SR_POLICY == 1)      w_next[i] = 1'b1;
                else if (SR_POLICY == 2) w_next[i] = 1'b0;
                else                     w_next[i] = r_q[i];
              end
              default: w_next[i] = r_q[i];
            endcase
          end
          MODE_JK: begin
            case ({a[i], b[i]})
              2'b10:   w_next[i] = 1'b1;
              2'b01:   w_next[i] = 1'b0;
              2'b11:   w_next[i] = ~r_q[i];
              default: w_next[i] = r_q[i];
            endcase
          end
          MODE_D:  w_next[i] = a[i];
          MODE_T:  w_next[i] = r_q[i] ^ a[i];
          default: w_next[i] = r_q[i];
        endcase
      end
    end
  end

  // One event per cycle no matter how many bits see S=R=1.
  assign w_event   = (mode == MODE_SR) && (|(en & a & b));
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q       <= RESET_VAL;
      r_qb      <= ~RESET_VAL;
      r_illegal <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_q  <= w_next;
      r_qb <= ~w_next;
      // A clear coinciding with an event restarts the count at that event.
      if (illegal_clr) begin
        r_illegal <= w_event;
        r_cnt     <= w_event ? CNT_W'(1) : '0;
      end else if (w_event) begin
        r_illegal <= 1'b1;
        r_cnt     <= w_cnt_inc;
      end
    end
  end

  assign q           = r_q;
  assign qb          = r_qb;
  assign illegal     = r_illegal;
  assign illegal_cnt = r_cnt;

endmodule

// File: tb/tb_multi_ff_bank.sv
// Self-checking bench: three multi_ff_bank instances (SR policies hold/set/reset)
// driven in parallel, checked every cycle against a vector-level model plus literals.
module tb_multi_ff_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode;
  logic [7:0] en, a, b;
  logic       clr;

  logic [7:0] q0, qb0, q1, qb1, q2, qb2;
  logic       il0, il1, il2;
  logic [1:0] cnt0, cnt1;
  logic [7:0] cnt2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  multi_ff_bank #(.WIDTH(8), .CNT_W(2), .RESET_VAL(8'hA5), .SR_POLICY(0)) dut0 (
    .clk(clk), .rst(rst), .mode(mode), .en(en), .a(a), .b(b), .illegal_clr(clr),
    .q(q0), .qb(qb0), .illegal(il0), .illegal_cnt(cnt0));
  multi_ff_bank #(.WIDTH(8), .CNT_W(2), .RESET_VAL(8'hA5), .SR_POLICY(1)) dut1 (
    .clk(clk), .rst(rst), .mode(mode), .en(en), .a(a), .b(b), .illegal_clr(clr),
    .q(q1), .qb(qb1), .illegal(il1), .illegal_cnt(cnt1));
  multi_ff_bank #(.WIDTH(8), .CNT_W(8), .RESET_VAL(8'hA5), .SR_POLICY(2)) dut2 (
    .clk(clk), .rst(rst), .mode(mode), .en(en), .a(a), .b(b), .illegal_clr(clr),
    .q(q2), .qb(qb2), .illegal(il2), .illegal_cnt(cnt2));

  // Reference model, one slot per instance.
  logic [7:0] m_q   [3];
  int         m_cnt [3];
  logic       m_ill [3];
  bit         m_valid = 0;
  int         cnt_max [3] = '{3, 3, 255};

  function automatic logic [7:0] model_next(logic [7:0] cq, logic [1:0] m, logic [7:0] e,
                                            logic [7:0] s, logic [7:0] r, int pol);
    logic [7:0] both = s & r;
    logic [7:0] nq;
    case (m)
      2'd0: begin
        nq = (cq & ~r) | s;
        if (pol == 0)      nq = (nq & ~both) | (cq & both);
        else if (pol == 1) nq = nq | both;
        else               nq = nq & ~both;
      end
      2'd1:    nq = (s & ~cq) | (~r & cq);
      2'd2:    nq = s;
      default: nq = cq ^ s;
    endcase
    return (nq & e) | (cq & ~e);
  endfunction

  always @(posedge clk) begin
    bit ev;
    ev = (mode == 2'd0) && ((en & a & b) != 8'h00);
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_q[k] = 8'hA5; m_cnt[k] = 0; m_ill[k] = 1'b0;
      end else if (m_valid) begin
        m_q[k] = model_next(m_q[k], mode, en, a, b, k);
        if (clr) begin
          m_cnt[k] = ev ? 1 : 0; m_ill[k] = ev;
        end else if (ev) begin
          m_cnt[k] = (m_cnt[k] < cnt_max[k]) ? m_cnt[k] + 1 : cnt_max[k];
          m_ill[k] = 1'b1;
        end
      end
    end
    if (rst) m_valid = 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Continuous compare against the model on the falling edge.
  logic [7:0] d_q [3], d_qb [3], d_cnt [3];
  logic       d_il [3];
  assign d_q[0] = q0;  assign d_qb[0] = qb0; assign d_cnt[0] = {6'd0, cnt0}; assign d_il[0] = il0;
  assign d_q[1] = q1;  assign d_qb[1] = qb1; assign d_cnt[1] = {6'd0, cnt1}; assign d_il[1] = il1;
  assign d_q[2] = q2;  assign d_qb[2] = qb2; assign d_cnt[2] = cnt2;         assign d_il[2] = il2;

  always @(negedge clk) begin
    if (m_valid) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("model_q[%0d]", k),   {24'd0, d_q[k]},  {24'd0, m_q[k]});
        chk($sformatf("model_qb[%0d]", k),  {24'd0, d_qb[k]}, {24'd0, ~m_q[k]});
        chk($sformatf("model_ill[%0d]", k), {31'd0, d_il[k]}, {31'd0, m_ill[k]});
        chk($sformatf("model_cnt[%0d]", k), {24'd0, d_cnt[k]}, m_cnt[k]);
      end
    end
  end

  task automatic drive(input logic r, input logic [1:0] m, input logic [7:0] e,
                       input logic [7:0] s, input logic [7:0] rr, input logic c);
    rst = r; mode = m; en = e; a = s; b = rr; clr = c;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: timeout expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1, 2'd2, 8'hFF, 8'h00, 8'h00, 0);
    tick(); tick();
    chk("rst_q", {24'd0, q0}, 32'hA5);
    chk("rst_qb", {24'd0, qb0}, 32'h5A);
    chk("rst_ill", {31'd0, il0}, 0);
    chk("rst_cnt", {30'd0, cnt0}, 0);

    // SR sweep on bit 0; q starts at A5 so bit 0 is already 1.
    drive(0, 2'd0, 8'h01, 8'h01, 8'h00, 0); tick(); chk("sr_10", {24'd0, q0}, 32'hA5);
    drive(0, 2'd0, 8'h01, 8'h00, 8'h00, 0); tick(); chk("sr_00", {24'd0, q0}, 32'hA5);
    drive(0, 2'd0, 8'h01, 8'h00, 8'h01, 0); tick(); chk("sr_01", {24'd0, q0}, 32'hA4);
    drive(0, 2'd0, 8'h01, 8'h01, 8'h01, 0); tick();
    chk("sr_11_hold", {24'd0, q0}, 32'hA4);
    chk("sr_11_set", {24'd0, q1}, 32'hA5);
    chk("sr_11_reset", {24'd0, q2}, 32'hA4);
    chk("sr_ill", {31'd0, il0}, 1);
    chk("sr_cnt", {30'd0, cnt0}, 1);

    drive(0, 2'd2, 8'h00, 8'h00, 8'h00, 1); tick();
    chk("clr_ill", {31'd0, il0}, 0);
    chk("clr_cnt", {30'd0, cnt0}, 0);

    // JK toggle then T.
    drive(0, 2'd2, 8'hFF, 8'h00, 8'h00, 0); tick(); chk("d_zero", {24'd0, q0}, 0);
    drive(0, 2'd1, 8'hFF, 8'hFF, 8'hFF, 0);
    tick(); chk("jk_t1", {24'd0, q0}, 32'hFF);
    tick(); chk("jk_t2", {24'd0, q0}, 32'h00);
    tick(); chk("jk_t3", {24'd0, q0}, 32'hFF);
    chk("jk_no_ill", {31'd0, il0}, 0);
    drive(0, 2'd3, 8'hFF, 8'h0F, 8'h00, 0); tick(); chk("t_0F", {24'd0, q0}, 32'hF0);

    // Per-bit enable.
    drive(0, 2'd2, 8'hFF, 8'h00, 8'h00, 0); tick();
    drive(0, 2'd2, 8'h55, 8'hFF, 8'h00, 0); tick();
    chk("en_q", {24'd0, q0}, 32'h55);
    chk("en_qb", {24'd0, qb0}, 32'hAA);
    drive(0, 2'd2, 8'h00, 8'h00, 8'h00, 0);
    for (int i = 0; i < 5; i++) begin
      tick(); chk("en_hold", {24'd0, q0}, 32'h55);
    end

    // Saturating counter (CNT_W=2 on dut0, CNT_W=8 on dut2).
    drive(0, 2'd0, 8'hFF, 8'hFF, 8'hFF, 0);
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("cnt_sat", {30'd0, cnt0}, (i < 3) ? i : 3);
      chk("cnt_wide", {24'd0, cnt2}, i);
    end
    drive(0, 2'd0, 8'hFF, 8'hFF, 8'hFF, 1); tick();
    chk("clr_ev_cnt", {30'd0, cnt0}, 1);
    chk("clr_ev_ill", {31'd0, il0}, 1);
    drive(0, 2'd2, 8'h00, 8'h00, 8'h00, 1); tick();
    chk("clr_noev_cnt", {30'd0, cnt0}, 0);
    chk("clr_noev_ill", {31'd0, il0}, 0);

    // Reset mid-toggle with a forbidden SR input present.
    drive(0, 2'd3, 8'hFF, 8'hFF, 8'h00, 0);
    tick(); chk("mid_t1", {24'd0, q0}, 32'hAA);
    tick(); chk("mid_t2", {24'd0, q0}, 32'h55);
    drive(1, 2'd0, 8'hFF, 8'hFF, 8'hFF, 0); tick();
    chk("mid_rst_q", {24'd0, q0}, 32'hA5);
    chk("mid_rst_cnt", {30'd0, cnt0}, 0);
    chk("mid_rst_ill", {31'd0, il0}, 0);
    drive(0, 2'd3, 8'hFF, 8'hFF, 8'h00, 0); tick();
    chk("mid_resume", {24'd0, q0}, 32'h5A);

    // Randomized phase, checked by the model process.
    for (int i = 0; i < 500; i++) begin
      drive(($urandom_range(0, 49) == 0), 2'($urandom_range(0, 3)), 8'($urandom),
            8'($urandom), 8'($urandom), ($urandom_range(0, 7) == 0));
      tick();
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
